grf_wb_queue: RTL

Write-back buffer sitting in front of the grf write port. Accepts register-write requests (PC, destination, data) from execute/memory-side producers over a valid/ready handshake, holds them in an in-order FIFO, and drains one per cycle into the grf write port. Also provides a two-port pending-write lookup so decode-side readers can forward the newest not-yet-committed value.

---
 rtl/grf_wb_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/grf_wb_queue.sv
// In-order write-back queue in front of the grf write port, with newest-wins forwarding lookup.
// Latency: at least 1 cycle from enqueue to out_we. Backpressure: in_ready = !full, independent of wb_ready.
// Optional GRF_WB_TRACE_EN prints each committed write on its dequeue edge.
module grf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [4:0]    in_addr,
  input  logic [31:0]   in_data,
  input  logic          wb_ready,
  output logic          out_we,
  output logic [31:0]   out_pc,
  output logic [4:0]    out_addr,
  output logic [31:0]   out_data,
  input  logic [4:0]    rd_addr1,
  input  logic [4:0]    rd_addr2,
  output logic          hit1,
  output logic          hit2,
  output logic [31:0]   fwd1,
  output logic [31:0]   fwd2,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]    pc_q   [DEPTH];
  logic [4:0]     addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]  head, tail;
  logic           enq, deq;
  logic [PW-1:0]  idx;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  // Writes to $0 complete the handshake but never occupy an entry.
  assign enq      = in_valid && in_ready && (in_addr != 5'd0);
  assign out_we   = valid_q[head];
  assign deq      = out_we && wb_ready;

  assign out_pc   = out_we ? pc_q[head]   : 32'd0;
  assign out_addr = out_we ? addr_q[head] : 5'd0;
  assign out_data = out_we ? data_q[head] : 32'd0;

  // Walk oldest to newest so the last match, the newest, wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = 32'd0;
    fwd2 = 32'd0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid_q[idx] && (rd_addr1 != 5'd0) && (addr_q[idx] == rd_addr1)) begin
        hit1 = 1'b1;
        fwd1 = data_q[idx];
      end
      if (valid_q[idx] && (rd_addr2 != 5'd0) && (addr_q[idx] == rd_addr2)) begin
        hit2 = 1'b1;
        fwd2 = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (deq) begin
        valid_q[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; out_* are masked while the head is invalid.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[tail]   <= in_pc;
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && deq)
      $display("@%h: $%d <= %h", out_pc, out_addr, out_data);
  end
`else
`endif

endmodule
